// File: rtl/rf_write_arbiter.sv
// Two-requester writeback arbiter in front of the single RegisterFile write port.
// Per-requester FIFOs, round-robin drain at one write per cycle, and RAW pending flags.
module rf_write_arbiter #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned AWIDTH = 5,
    parameter int unsigned DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              AValid,
    output logic              AReady,
    input  logic [AWIDTH-1:0] AReg,
    input  logic [DWIDTH-1:0] AData,
    input  logic              BValid,
    output logic              BReady,
    input  logic [AWIDTH-1:0] BReg,
    input  logic [DWIDTH-1:0] BData,
    output logic [AWIDTH-1:0] WriteReg,
    output logic [1:0]        RegWrite,
    output logic [DWIDTH-1:0] WriteData,
    input  logic [AWIDTH-1:0] Read1,
    input  logic [AWIDTH-1:0] Read2,
    output logic              Pend1,
    output logic              Pend2,
    output logic              Idle
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned NQ = 2;
    localparam logic [1:0]  RW_WRITE = 2'b01;
    localparam logic [1:0]  RW_IDLE  = 2'b00;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } grant_e;

    // Queue 0 is requester A, queue 1 is requester B.
    logic [PW-1:0]     r_wptr  [NQ];
    logic [PW-1:0]     r_rptr  [NQ];
    logic [CW-1:0]     r_count [NQ];
    logic [DEPTH-1:0]  r_vld   [NQ];
    logic [AWIDTH-1:0] r_qreg  [NQ][DEPTH];
    logic [DWIDTH-1:0] r_qdata [NQ][DEPTH];

    grant_e            r_last;
    grant_e            w_last_nxt;

    logic [AWIDTH-1:0] w_in_reg  [NQ];
    logic [DWIDTH-1:0] w_in_data [NQ];
    logic [NQ-1:0]     w_valid;
    logic [NQ-1:0]     w_ready;
    logic [NQ-1:0]     w_ne;
    logic [NQ-1:0]     w_push;
    logic [NQ-1:0]     w_pop;
    logic              w_match1;
    logic              w_match2;
    logic              w_out_live;

    assign w_in_reg[0]  = AReg;
    assign w_in_reg[1]  = BReg;
    assign w_in_data[0] = AData;
    assign w_in_data[1] = BData;
    assign w_valid      = {BValid, AValid};

    // Ready and non-empty come straight from the registered counts; no pass-through.
    always_comb begin
        w_ready = '0;
        w_ne    = '0;
        w_push  = '0;
        for (int q = 0; q < int'(NQ); q++) begin
            w_ready[q] = (r_count[q] != CW'(DEPTH));
            w_ne[q]    = (r_count[q] != '0);
            // Writes to r0 complete the handshake but are dropped.
            w_push[q]  = w_valid[q] && w_ready[q] && (w_in_reg[q] != '0);
        end
    end

    assign AReady = w_ready[0];
    assign BReady = w_ready[1];

    // Round-robin grant: on a tie, the requester not granted last time wins.
    always_comb begin
        w_pop      = '0;
        w_last_nxt = r_last;
        if (w_ne[0] && w_ne[1]) begin
            if (r_last == GNT_B) begin
                w_pop[0]   = 1'b1;
                w_last_nxt = GNT_A;
            end else begin
                w_pop[1]   = 1'b1;
                w_last_nxt = GNT_B;
            end
        end else if (w_ne[0]) begin
            w_pop[0]   = 1'b1;
            w_last_nxt = GNT_A;
        end else if (w_ne[1]) begin
            w_pop[1]   = 1'b1;
            w_last_nxt = GNT_B;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= GNT_B;
        end else begin
            r_last <= w_last_nxt;
        end
    end

    // FIFO storage; push and pop never touch the same slot in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int q = 0; q < int'(NQ); q++) begin
                r_wptr[q]  <= '0;
                r_rptr[q]  <= '0;
                r_count[q] <= '0;
                r_vld[q]   <= '0;
                for (int i = 0; i < int'(DEPTH); i++) begin
                    r_qreg[q][i]  <= '0;
                    r_qdata[q][i] <= '0;
                end
            end
        end else begin
            for (int q = 0; q < int'(NQ); q++) begin
                if (w_push[q]) begin
                    r_qreg[q][r_wptr[q]]  <= w_in_reg[q];
                    r_qdata[q][r_wptr[q]] <= w_in_data[q];
                    r_vld[q][r_wptr[q]]   <= 1'b1;
                    r_wptr[q]             <= r_wptr[q] + PW'(1);
                end
                if (w_pop[q]) begin
                    r_vld[q][r_rptr[q]] <= 1'b0;
                    r_rptr[q]           <= r_rptr[q] + PW'(1);
                end
                case ({w_push[q], w_pop[q]})
                    2'b10:   r_count[q] <= r_count[q] + CW'(1);
                    2'b01:   r_count[q] <= r_count[q] - CW'(1);
                    default: r_count[q] <= r_count[q];
                endcase
            end
        end
    end

    // Registered RF write port; address and data hold when nothing issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WriteReg  <= '0;
            WriteData <= '0;
            RegWrite  <= RW_IDLE;
        end else if (w_pop[0]) begin
            WriteReg  <= r_qreg[0][r_rptr[0]];
            WriteData <= r_qdata[0][r_rptr[0]];
            RegWrite  <= RW_WRITE;
        end else if (w_pop[1]) begin
            WriteReg  <= r_qreg[1][r_rptr[1]];
            WriteData <= r_qdata[1][r_rptr[1]];
            RegWrite  <= RW_WRITE;
        end else begin
            RegWrite  <= RW_IDLE;
        end
    end

    always_comb begin
        w_match1 = 1'b0;
        w_match2 = 1'b0;
        for (int q = 0; q < int'(NQ); q++) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (r_vld[q][i] && (r_qreg[q][i] == Read1)) w_match1 = 1'b1;
                if (r_vld[q][i] && (r_qreg[q][i] == Read2)) w_match2 = 1'b1;
            end
        end
    end

    // The write on the output stage is still pending until the RF takes it.
    assign w_out_live = (RegWrite == RW_WRITE);
    assign Pend1 = (Read1 != '0) && (w_match1 || (w_out_live && (WriteReg == Read1)));
    assign Pend2 = (Read2 != '0) && (w_match2 || (w_out_live && (WriteReg == Read2)));
    assign Idle  = !w_ne[0] && !w_ne[1] && (RegWrite == RW_IDLE);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a small RegisterFile model on the write port.
module tb_rf_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        AValid, BValid;
    logic        AReady, BReady;
    logic [4:0]  AReg, BReg;
    logic [31:0] AData, BData;
    logic [4:0]  WriteReg;
    logic [1:0]  RegWrite;
    logic [31:0] WriteData;
    logic [4:0]  Read1, Read2;
    logic        Pend1, Pend2, Idle;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] rf [32];

    rf_write_arbiter #(.DEPTH(2), .AWIDTH(5), .DWIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .AValid(AValid), .AReady(AReady), .AReg(AReg), .AData(AData),
        .BValid(BValid), .BReady(BReady), .BReg(BReg), .BData(BData),
        .WriteReg(WriteReg), .RegWrite(RegWrite), .WriteData(WriteData),
        .Read1(Read1), .Read2(Read2), .Pend1(Pend1), .Pend2(Pend2), .Idle(Idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RegisterFile model: writes on the edge after the port shows RegWrite = 01.
    always @(posedge clk) begin
        if (RegWrite == 2'b01) rf[WriteReg] <= WriteData;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        AValid = 1'b0; AReg = '0; AData = '0;
        BValid = 1'b0; BReg = '0; BData = '0;
        Read1 = '0; Read2 = '0;

        // Asynchronous reset before any clock edge
        #3 rst_n = 1'b0;
        #1;
        chk("rst_regwrite", 64'(RegWrite), 64'd0);
        chk("rst_writereg", 64'(WriteReg), 64'd0);
        chk("rst_aready",   64'(AReady),   64'd1);
        chk("rst_bready",   64'(BReady),   64'd1);
        chk("rst_idle",     64'(Idle),     64'd1);
        #8 rst_n = 1'b1;
        tick();

        // Single A write r5
        Read1 = 5'd5;
        #1;
        chk("r5_pend_before", 64'(Pend1), 64'd0);
        AValid = 1'b1; AReg = 5'd5; AData = 32'h5555_5555;
        tick();
        AValid = 1'b0;
        #1;
        chk("r5_pend_queued", 64'(Pend1),    64'd1);
        chk("r5_rw_accept",   64'(RegWrite), 64'd0);
        tick();
        chk("r5_rw_issue",    64'(RegWrite), 64'd1);
        chk("r5_wreg",        64'(WriteReg), 64'd5);
        chk("r5_wdata",       64'(WriteData), 64'h5555_5555);
        chk("r5_pend_issue",  64'(Pend1),    64'd1);
        tick();
        chk("r5_rw_after",    64'(RegWrite), 64'd0);
        chk("r5_pend_after",  64'(Pend1),    64'd0);
        chk("r5_rf_read",     64'(rf[5]),    64'h5555_5555);
        chk("r5_idle",        64'(Idle),     64'd1);

        // Simultaneous A/B after reset: A wins the first tie
        pulse_reset();
        AValid = 1'b1; AReg = 5'd5;  AData = 32'h5555_5555;
        BValid = 1'b1; BReg = 5'd10; BData = 32'hAAAA_AAAA;
        tick();
        AValid = 1'b0; BValid = 1'b0;
        tick();
        chk("tie_first_reg",  64'(WriteReg),  64'd5);
        chk("tie_first_data", 64'(WriteData), 64'h5555_5555);
        tick();
        chk("tie_second_rw",   64'(RegWrite),  64'd1);
        chk("tie_second_reg",  64'(WriteReg),  64'd10);
        chk("tie_second_data", 64'(WriteData), 64'hAAAA_AAAA);
        tick();
        chk("tie_done_rw", 64'(RegWrite), 64'd0);

        // Sustained dual traffic alternates A, B, A, B
        AValid = 1'b1; AReg = 5'd1; AData = 32'h1111_0000;
        BValid = 1'b1; BReg = 5'd2; BData = 32'h2222_0000;
        tick();
        chk("alt_fill_rw", 64'(RegWrite), 64'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("alt_rw_%0d", i),  64'(RegWrite), 64'd1);
            chk($sformatf("alt_reg_%0d", i), 64'(WriteReg), (i % 2 == 0) ? 64'd1 : 64'd2);
        end
        AValid = 1'b0; BValid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!Idle) tick();
        end
        chk("alt_drained_idle", 64'(Idle), 64'd1);

        // A alone, three registers in order
        AValid = 1'b1; AReg = 5'd1; AData = 32'h1111_1111;
        tick();
        AReg = 5'd2; AData = 32'h2222_2222;
        #1;
        chk("seq_ready_1", 64'(AReady), 64'd1);
        tick();
        chk("seq_reg_1",  64'(WriteReg),  64'd1);
        chk("seq_data_1", 64'(WriteData), 64'h1111_1111);
        AReg = 5'd3; AData = 32'h3333_3333;
        #1;
        chk("seq_ready_2", 64'(AReady), 64'd1);
        tick();
        chk("seq_reg_2",  64'(WriteReg),  64'd2);
        chk("seq_data_2", 64'(WriteData), 64'h2222_2222);
        AValid = 1'b0;
        tick();
        chk("seq_reg_3",  64'(WriteReg),  64'd3);
        chk("seq_data_3", 64'(WriteData), 64'h3333_3333);
        tick();
        chk("seq_done_rw", 64'(RegWrite), 64'd0);
        chk("seq_idle",    64'(Idle),     64'd1);

        // Write to r0 is accepted and dropped
        Read1 = 5'd0;
        AValid = 1'b1; AReg = 5'd0; AData = 32'hFFFF_FFFF;
        #1;
        chk("r0_ready", 64'(AReady), 64'd1);
        tick();
        AValid = 1'b0;
        #1;
        chk("r0_rw_accept", 64'(RegWrite), 64'd0);
        chk("r0_pend",      64'(Pend1),    64'd0);
        chk("r0_idle",      64'(Idle),     64'd1);
        tick();
        chk("r0_rw_next",   64'(RegWrite), 64'd0);

        // Load both queues, then flush with reset mid-cycle (last grant is A here)
        Read1 = 5'd7; Read2 = 5'd9;
        AValid = 1'b1; AReg = 5'd7; AData = 32'h7777_7777;
        BValid = 1'b1; BReg = 5'd9; BData = 32'h9999_9999;
        tick();
        tick();
        chk("fill_rw",     64'(RegWrite), 64'd1);
        chk("fill_reg_b",  64'(WriteReg), 64'd9);
        chk("fill_aready", 64'(AReady),   64'd0);
        chk("fill_bready", 64'(BReady),   64'd1);
        chk("fill_pend1",  64'(Pend1),    64'd1);
        chk("fill_pend2",  64'(Pend2),    64'd1);
        AValid = 1'b0; BValid = 1'b0;
        pulse_reset();
        #1;
        chk("flush_rw",     64'(RegWrite), 64'd0);
        chk("flush_idle",   64'(Idle),     64'd1);
        chk("flush_pend1",  64'(Pend1),    64'd0);
        chk("flush_pend2",  64'(Pend2),    64'd0);
        chk("flush_aready", 64'(AReady),   64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("flush_quiet_%0d", i), 64'(RegWrite), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
